pipe_shifter: RTL and testbench

Parametrised, fully pipelined barrel shifter for the TPU datapath. It accepts an IN_W-bit operand, a shift amount and a shift mode through a valid/ready handshake. The operand is widened to OUT_W bits and shifted one binary stage per clock. The block returns the result with a per-result error flag: lost set bits for logical and arithmetic shifts, always clear for rotate. It replaces the combinational left-only shifter between the multiplier array and the accumulators, and adds right, arithmetic and rotate modes plus back-pressure.

---
 rtl/pipe_shifter_if.sv | 28 ++
 rtl/pipe_shifter.sv | 121 ++++++++++++
 tb/tb_pipe_shifter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_shifter_if.sv
// Operand/result handshake bundle for pipe_shifter.
interface pipe_shifter_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 34,
    parameter int unsigned SH_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [SH_W-1:0]  in_shift;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_error;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_shift, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_error
    );

    // Shifter side
    modport slave (
        input  in_valid, in_data, in_shift, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_error
    );
endinterface

// File: rtl/pipe_shifter.sv
// Fully pipelined barrel shifter: one binary shift stage per clock, with
// lost-bit error tracking and a globally stalling valid/ready pipeline.
module pipe_shifter #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 34,
    parameter int unsigned SH_W  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_shifter_if.slave  io,
    output logic           busy
);

    localparam int unsigned LAST = SH_W - 1;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // Per-stage payload; shift holds the not-yet-applied amount bits, LSB next.
    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [SH_W-1:0]  shift;
        logic [1:0]       mode;
        logic             err;
        logic             valid;
    } stage_t;

    stage_t stg_q [SH_W];
    stage_t stg_d [SH_W];
    stage_t in_stage;
    logic   stall;

    // Apply stage k (shift by 2^k if the current shift LSB is set).
    function automatic stage_t stage_step(input stage_t s, input int unsigned k);
        stage_t           r;
        logic [OUT_W-1:0] ones;
        logic [OUT_W-1:0] lost;
        int unsigned      amt;
        int unsigned      rot;
        r       = s;
        r.shift = s.shift >> 1;
        ones    = '1;
        lost    = '0;
        amt     = 32'd1 << k;
        rot     = 0;
        if (s.shift[0]) begin
            case (s.mode)
                MODE_LSL: begin
                    r.data = s.data << amt;
                    lost   = s.data & ~(ones >> amt);
                end
                MODE_LSR: begin
                    r.data = s.data >> amt;
                    lost   = s.data & ~(ones << amt);
                end
                MODE_ASR: begin
                    r.data = OUT_W'($signed(s.data) >>> amt);
                    lost   = s.data & ~(ones << amt);
                end
                default: begin
                    // Rotate wraps within OUT_W; nothing is ever lost.
                    rot    = amt % OUT_W;
                    r.data = (s.data << rot) | (s.data >> (OUT_W - rot));
                end
            endcase
        end
        r.err = s.err | (|lost);
        return r;
    endfunction

    assign stall       = io.out_valid & ~io.out_ready;
    assign io.in_ready = ~stall;

    // Widen the incoming operand into a stage-0 input record.
    always_comb begin
        in_stage       = '0;
        in_stage.shift = io.in_shift;
        in_stage.mode  = io.in_mode;
        in_stage.valid = io.in_valid & ~stall;
        if (io.in_mode == MODE_ASR) begin
            in_stage.data = OUT_W'($signed(io.in_data));
        end else begin
            in_stage.data = OUT_W'(io.in_data);
        end
    end

    // Next-state of every stage.
    always_comb begin
        stg_d[0] = stage_step(in_stage, 0);
        for (int k = 1; k < SH_W; k++) begin
            stg_d[k] = stage_step(stg_q[k-1], 32'(k));
        end
    end

    // Stage registers: whole pipeline holds on stall, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SH_W; k++) begin
                stg_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < SH_W; k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    // Activity indicator across all stages.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < SH_W; k++) begin
            busy = busy | stg_q[k].valid;
        end
    end

    assign io.out_valid = stg_q[LAST].valid;
    assign io.out_data  = stg_q[LAST].data;
    assign io.out_error = stg_q[LAST].err;

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench for pipe_shifter: directed vector table, random stream
// against a total-shift reference model, and a mid-flight reset sequence.
module tb_pipe_shifter;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 34;
    localparam int unsigned SH_W  = 5;

    logic clk;
    logic rst_n;
    logic busy;

    int checks = 0;
    int errors = 0;

    pipe_shifter_if #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)) bus ();

    pipe_shifter #(.IN_W(IN_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  data;
        logic [SH_W-1:0]  sh;
        logic [1:0]       mode;
        logic [OUT_W-1:0] exp_data;
        logic             exp_err;
        string            name;
    } vec_t;

    vec_t vecs [12];
    logic [OUT_W:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: apply the whole shift at once on a wide integer.
    function automatic logic [OUT_W:0] model(input logic [IN_W-1:0] d,
                                            input logic [SH_W-1:0] sh,
                                            input logic [1:0] mode);
        logic [127:0]     x;
        logic [127:0]     y;
        logic [127:0]     mask;
        logic [OUT_W-1:0] res;
        logic             err;
        int               r;
        if (mode == 2'b10) x = 128'($signed(d));
        else               x = 128'(d);
        mask = (128'd1 << sh) - 128'd1;
        res  = '0;
        err  = 1'b0;
        case (mode)
            2'b00: begin
                y   = x << sh;
                res = y[OUT_W-1:0];
                err = |(y >> OUT_W);
            end
            2'b01: begin
                res = OUT_W'(x >> sh);
                err = |(x & mask);
            end
            2'b10: begin
                res = OUT_W'($signed(x) >>> sh);
                err = |(x & mask);
            end
            default: begin
                r = int'(sh) % OUT_W;
                for (int i = 0; i < OUT_W; i++) res[(i + r) % OUT_W] = x[i];
            end
        endcase
        return {err, res};
    endfunction

    // One isolated operand: checks acceptance, latency and result.
    task automatic run_one(input vec_t v);
        int lat;
        bus.in_data   = v.data;
        bus.in_shift  = v.sh;
        bus.in_mode   = v.mode;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({v.name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check({v.name, "_latency"}, 64'(lat), 64'(SH_W - 1));
        check({v.name, "_data"}, 64'(bus.out_data), 64'(v.exp_data));
        check({v.name, "_err"}, 64'(bus.out_error), 64'(v.exp_err));
    endtask

    // Random operands with random back-pressure, scoreboarded in order.
    task automatic random_stream(input int n);
        int               issued = 0;
        int               got = 0;
        int               cyc = 0;
        int               extra = 0;
        logic             pending = 1'b0;
        logic             prev_stall = 1'b0;
        logic [OUT_W-1:0] prev_data = '0;
        logic             prev_err = 1'b0;
        logic [OUT_W:0]   e;
        exp_q.delete();
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
                check("stall_hold_data", 64'(bus.out_data), 64'(prev_data));
                check("stall_hold_err", 64'(bus.out_error), 64'(prev_err));
            end
            bus.out_ready = ($urandom_range(0, 99) < 60);
            if (!pending && issued < n && $urandom_range(0, 3) != 0) begin
                bus.in_data  = IN_W'($urandom);
                bus.in_shift = SH_W'($urandom);
                bus.in_mode  = 2'($urandom);
                bus.in_valid = 1'b1;
                pending      = 1'b1;
            end else if (!pending) begin
                bus.in_valid = 1'b0;
            end
            #1;
            check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("stream_data_%0d", got), 64'(bus.out_data), 64'(e[OUT_W-1:0]));
                    check($sformatf("stream_err_%0d", got), 64'(bus.out_error), 64'(e[OUT_W]));
                    got++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_err   = bus.out_error;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_data, bus.in_shift, bus.in_mode));
                issued++;
                pending = 1'b0;
            end
        end
        check("stream_count", 64'(got), 64'(n));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        check("stream_no_extra", 64'(extra), 64'd0);
    endtask

    // Reset while results are in flight; nothing flushed may reappear.
    task automatic reset_midflight();
        int   seen = 0;
        vec_t v;
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = IN_W'(8'h11 * (i + 1));
            bus.in_shift = SH_W'(i + 1);
            bus.in_mode  = 2'b00;
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_data", 64'(bus.out_data), 64'd0);
        check("rst_mid_err", 64'(bus.out_error), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_flushed_none", 64'(seen), 64'd0);
        v = '{8'h05, 5'd4, 2'b00, 34'h50, 1'b0, "post_rst_lsl"};
        run_one(v);
    endtask

    initial begin
        vecs[0]  = '{8'h01, 5'd31, 2'b00, 34'h0_8000_0000, 1'b0, "lsl_01_31"};
        vecs[1]  = '{8'hFF, 5'd31, 2'b00, 34'h3_8000_0000, 1'b1, "lsl_ff_31"};
        vecs[2]  = '{8'h81, 5'd1,  2'b01, 34'h0_0000_0040, 1'b1, "lsr_81_1"};
        vecs[3]  = '{8'hFB, 5'd1,  2'b10, 34'h3_FFFF_FFFD, 1'b1, "asr_fb_1"};
        // Sign-extension ones pushed below bit 0 count as discarded set bits.
        vecs[4]  = '{8'h80, 5'd31, 2'b10, 34'h3_FFFF_FFFF, 1'b1, "asr_80_31"};
        vecs[5]  = '{8'h80, 5'd31, 2'b11, 34'h0_0000_0010, 1'b0, "rol_80_31"};
        vecs[6]  = '{8'h00, 5'd31, 2'b00, 34'h0_0000_0000, 1'b0, "lsl_00_31"};
        vecs[7]  = '{8'hAB, 5'd0,  2'b01, 34'h0_0000_00AB, 1'b0, "lsr_ab_0"};
        vecs[8]  = '{8'h7F, 5'd3,  2'b10, 34'h0_0000_000F, 1'b1, "asr_7f_3"};
        vecs[9]  = '{8'hFF, 5'd30, 2'b11, 34'h3_C000_000F, 1'b0, "rol_ff_30"};
        vecs[10] = '{8'hFF, 5'd26, 2'b00, 34'h3_FC00_0000, 1'b0, "lsl_ff_26"};
        vecs[11] = '{8'hFF, 5'd27, 2'b00, 34'h3_F800_0000, 1'b1, "lsl_ff_27"};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shift  = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        #12;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_data", 64'(bus.out_data), 64'd0);
        check("reset_out_error", 64'(bus.out_error), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) run_one(vecs[i]);

        random_stream(40);
        reset_midflight();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
